// File: rtl/lut_rev_search.sv
// lut_rev_search: programmable key/data table with a sequential data->key reverse lookup
module lut_rev_search #(
  parameter int NR_KEY     = 4,
  parameter int KEY_WIDTH  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       clr,
  input  logic                                       wr_en,
  input  logic [IDX_WIDTH-1:0]                       wr_idx,
  input  logic [KEY_WIDTH-1:0]                       wr_key,
  input  logic [DATA_WIDTH-1:0]                      wr_data,
  output logic [NR_KEY*(KEY_WIDTH+DATA_WIDTH)-1:0]   lut,
  output logic [NR_KEY-1:0]                          lut_vld,
  input  logic                                       q_valid,
  output logic                                       q_ready,
  input  logic [DATA_WIDTH-1:0]                      q_data,
  output logic                                       r_valid,
  input  logic                                       r_ready,
  output logic                                       r_hit,
  output logic [KEY_WIDTH-1:0]                       r_key,
  output logic [IDX_WIDTH-1:0]                       r_idx
);
  localparam int PAIR = KEY_WIDTH + DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  state_t                r_state, w_next;
  logic [KEY_WIDTH-1:0]  r_keys  [NR_KEY];
  logic [DATA_WIDTH-1:0] r_datas [NR_KEY];
  logic [NR_KEY-1:0]     r_vld;
  logic [DATA_WIDTH-1:0] r_q;
  logic [IDX_WIDTH-1:0]  r_scan;
  logic                  w_wr, w_hit, w_last;
  assign w_wr    = wr_en && !clr && (int'(wr_idx) < NR_KEY);
  assign w_hit   = r_vld[r_scan] && (r_datas[r_scan] == r_q);
  assign w_last  = int'(r_scan) == NR_KEY - 1;
  assign q_ready = r_state == IDLE;
  assign r_valid = r_state == RESP;
  assign lut_vld = r_vld;
  for (genvar n = 0; n < NR_KEY; n++) begin : g_lut
    assign lut[PAIR*n +: PAIR] = {r_keys[n], r_datas[n]};
  end
  // table storage: clr drops every valid bit and beats a simultaneous write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        r_keys[i]  <= '0;
        r_datas[i] <= '0;
      end
    end else begin
      if (clr) r_vld <= '0;
      if (w_wr) begin
        r_keys[wr_idx]  <= wr_key;
        r_datas[wr_idx] <= wr_data;
        r_vld[wr_idx]   <= 1'b1;
      end
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // next state: accept in IDLE, stop scanning on first hit or last entry, release on handshake
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (q_valid) w_next = SCAN;
      SCAN:    if (w_hit || w_last) w_next = RESP;
      RESP:    if (r_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // query latch, scan index and response capture; response holds through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_scan <= '0;
      r_hit  <= 1'b0;
      r_key  <= '0;
      r_idx  <= '0;
    end else if (r_state == IDLE && q_valid) begin
      r_q    <= q_data;
      r_scan <= '0;
    end else if (r_state == SCAN) begin
      if (w_hit) begin
        r_hit <= 1'b1;
        r_key <= r_keys[r_scan];
        r_idx <= r_scan;
      end else if (w_last) begin
        r_hit <= 1'b0;
        r_key <= '0;
        r_idx <= '0;
      end else begin
        r_scan <= r_scan + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lut_rev_search.sv
// tb_lut_rev_search: table-driven reverse-lookup checks with a response scoreboard
module tb_lut_rev_search;
  logic clk = 0, rst_n = 0, clr = 0, wr_en = 0, q_valid = 0, r_ready = 0;
  logic [1:0] wr_idx = 0, wr_key = 0;
  logic [7:0] wr_data = 0, q_data = 0;
  logic [39:0] lut;
  logic [3:0] lut_vld;
  logic q_ready, r_valid, r_hit;
  logic [1:0] r_key, r_idx;
  logic [29:0] lut3, l3;
  logic [2:0] lut_vld3, v3;
  logic q_ready3, r_valid3, r_hit3;
  logic [1:0] r_key3, r_idx3;
  int errors = 0, checks = 0;
  typedef struct {logic hit; logic [1:0] key; logic [1:0] idx; int lat;} exp_t;
  typedef struct {logic [7:0] q; logic hit; logic [1:0] key; logic [1:0] idx; int lat;} vec_t;
  exp_t sb[$];
  vec_t v[5];

  lut_rev_search dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .lut(lut), .lut_vld(lut_vld), .q_valid(q_valid), .q_ready(q_ready),
    .q_data(q_data), .r_valid(r_valid), .r_ready(r_ready), .r_hit(r_hit), .r_key(r_key), .r_idx(r_idx)
  );

  lut_rev_search #(.NR_KEY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .lut(lut3), .lut_vld(lut_vld3), .q_valid(q_valid), .q_ready(q_ready3),
    .q_data(q_data), .r_valid(r_valid3), .r_ready(r_ready), .r_hit(r_hit3), .r_key(r_key3), .r_idx(r_idx3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] i, input logic [1:0] k, input logic [7:0] d, input logic c);
    wr_en = 1; wr_idx = i; wr_key = k; wr_data = d; clr = c;
    @(posedge clk);
    #1 wr_en = 0; clr = 0;
  endtask

  task automatic query(input logic [7:0] d, input logic hit, input logic [1:0] k, input logic [1:0] i,
                       input int lat, input int hold, input int clr_at);
    exp_t e;
    int n;
    chk("q_ready_before", q_ready, 1);
    e = '{hit, k, i, lat};
    sb.push_back(e);
    q_valid = 1; q_data = d;
    @(posedge clk);
    #1 q_valid = 0; q_data = ~d; n = 0;
    while (!r_valid && n < 20) begin
      clr = (n == clr_at);
      @(posedge clk);
      #1 n++;
    end
    clr = 0;
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("r_hit", r_hit, e.hit);
    chk("r_key", r_key, e.key);
    chk("r_idx", r_idx, e.idx);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1 chk("hold_valid", r_valid, 1);
      chk("hold_fields", {r_hit, r_key, r_idx}, {e.hit, e.key, e.idx});
      chk("hold_q_ready", q_ready, 0);
    end
    r_ready = 1;
    @(posedge clk);
    #1 r_ready = 0;
    chk("q_ready_after", q_ready, 1);
    chk("r_valid_after", r_valid, 0);
  endtask

  initial begin
    v[0] = '{8'h3C, 1'b1, 2'd1, 2'd2, 3};
    v[1] = '{8'hA5, 1'b1, 2'd2, 2'd0, 1};
    v[2] = '{8'h77, 1'b1, 2'd3, 2'd1, 2};
    v[3] = '{8'h55, 1'b0, 2'd0, 2'd0, 4};
    v[4] = '{8'h00, 1'b0, 2'd0, 2'd0, 4};
    repeat (2) @(posedge clk);
    #1 chk("rst_lut", lut, 0);
    chk("rst_lut_vld", lut_vld, 0);
    chk("rst_q_ready", q_ready, 1);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_resp", {r_hit, r_key, r_idx}, 0);
    rst_n = 1;
    @(posedge clk);
    #1 query(8'h00, 0, 0, 0, 4, 0, -1);
    wr(0, 2, 8'hA5, 0);
    wr(2, 1, 8'h3C, 0);
    chk("lut_pair2", lut[29:20], {2'b01, 8'h3C});
    chk("lut_pair0", lut[9:0], {2'b10, 8'hA5});
    chk("lut_vld_prog", lut_vld, 4'b0101);
    wr(1, 3, 8'h77, 0);
    wr(3, 0, 8'h77, 0);
    chk("lut_vld_full", lut_vld, 4'b1111);
    for (int j = 0; j < 5; j++) query(v[j].q, v[j].hit, v[j].key, v[j].idx, v[j].lat, 0, -1);
    query(8'h77, 1, 3, 1, 2, 5, -1);
    wr(3, 1, 8'h22, 1);
    chk("clr_priority", lut_vld, 0);
    wr(3, 2, 8'h11, 0);
    chk("lut_vld_idx3", lut_vld, 4'b1000);
    query(8'h11, 1, 2, 3, 4, 0, -1);
    query(8'h11, 0, 0, 0, 4, 0, 1);
    chk("mid_scan_clr_vld", lut_vld, 0);
    l3 = lut3; v3 = lut_vld3;
    wr(3, 1, 8'hEE, 0);
    chk("oor_lut", lut3, l3);
    chk("oor_vld", lut_vld3, v3);
    chk("main_idx3", lut[39:30], {2'b01, 8'hEE});
    wr(2, 3, 8'h44, 0);
    chk("dut3_idx2", lut3[29:20], {2'b11, 8'h44});
    q_valid = 1; q_data = 8'hEE;
    @(posedge clk);
    #1 q_valid = 0;
    @(posedge clk);
    #1 chk("scan_q_ready", q_ready, 0);
    rst_n = 0;
    #1 chk("arst_r_valid", r_valid, 0);
    chk("arst_q_ready", q_ready, 1);
    chk("arst_lut", lut, 0);
    chk("arst_lut_vld", lut_vld, 0);
    @(posedge clk);
    #1 rst_n = 1;
    repeat (6) @(posedge clk);
    #1 chk("arst_no_resp", r_valid, 0);
    chk("arst_idle", q_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lut_rev_search.md
Name: lut_rev_search

Overview:
- Programmable key/data table plus a sequential reverse-lookup engine: given a data value, it returns the key that maps to it.
- It is the data->key counterpart of the packed key->data mux lookup.
- It drives a packed LUT bus in the same pair format, so one table feeds the forward mux and answers reverse queries.
- Sits beside the decode/lookup logic. It is programmed by a control path and queried via valid/ready.

Parameters:
- NR_KEY, 4, number of table entries (>=2)
- KEY_WIDTH, 2, key width in bits
- DATA_WIDTH, 8, data width in bits
- IDX_WIDTH, 2, entry index width; 2**IDX_WIDTH >= NR_KEY

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous reset, active-low
- clr  in  1  invalidate all entries
- wr_en  in  1  write entry
- wr_idx  in  IDX_WIDTH  entry index to write
- wr_key  in  KEY_WIDTH  key to store
- wr_data  in  DATA_WIDTH  data to store
- lut  out  NR_KEY*(KEY_WIDTH+DATA_WIDTH)  packed table; entry n at [PAIR*(n+1)-1:PAIR*n], key in the upper KEY_WIDTH bits, data in the lower
- lut_vld  out  NR_KEY  per-entry valid mask
- q_valid  in  1  query request
- q_ready  out  1  engine idle, accepting a query
- q_data  in  DATA_WIDTH  data value to search for
- r_valid  out  1  response available
- r_ready  in  1  response consumed
- r_hit  out  1  a match was found
- r_key  out  KEY_WIDTH  key of the matching entry, 0 on miss
- r_idx  out  IDX_WIDTH  index of the matching entry, 0 on miss

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - all entries key=0, data=0, valid=0; lut=0, lut_vld=0
  - state IDLE, so q_ready=1
  - r_valid=0, r_hit=0, r_key=0, r_idx=0
- Table writes:
  - wr_en stores key, data and valid=1 at wr_idx on the clock edge. The new values are visible on lut/lut_vld the next cycle.
  - wr_idx >= NR_KEY is ignored.
  - clr clears every valid bit on the edge. Key and data contents are don't-care and are not cleared.
  - clr and wr_en in the same cycle: clr wins, the write is dropped.
- FSM states: IDLE, SCAN, RESP.
  - q_ready = (state==IDLE), combinational from state only.
  - IDLE: on q_valid&&q_ready, latch q_data, set scan idx=0, go to SCAN.
  - SCAN: one entry per cycle.
    - Hit (valid[idx] && data[idx]==latched q_data): capture r_hit=1, r_key=key[idx], r_idx=idx; go to RESP.
    - Else if idx==NR_KEY-1: capture r_hit=0, r_key=0, r_idx=0; go to RESP.
    - Else idx++.
  - RESP: r_valid=1. Response fields are held stable until r_ready. On r_valid&&r_ready go to IDLE; q_ready is 1 from the next cycle, so there is no back-to-back accept in the same cycle.
- Latency, counted in rising edges from the accept edge:
  - hit at entry i: r_valid asserted after i+1 edges
  - miss: r_valid asserted after NR_KEY edges
- Duplicate data values: the lowest index wins.
- Writes or clr during SCAN: the comparison uses table contents as registered in that cycle. Entries already passed are not rescanned. A clr mid-scan makes the remaining entries miss.
- Writes during RESP do not alter the held response.
- q_data changes after the accept edge have no effect.
- rst_n asserted mid-operation: immediately back to IDLE with reset values. Any in-flight query is dropped and no response is produced.
- Widths: comparisons are exact DATA_WIDTH equality; the index counter does not wrap past NR_KEY-1.

Test Plan:
- Reset then idle: rst_n low → lut=0, lut_vld=0, q_ready=1, r_valid=0. A query for 0x00 after release → miss response after 4 edges, r_hit=0, r_key=0, r_idx=0.
- Program and hit: write idx0 {key 2, data 0xA5}, idx2 {key 1, data 0x3C}; query 0x3C → r_valid 3 edges after accept, r_hit=1, r_key=1, r_idx=2. lut bits [29:20] = {2'b01, 8'h3C}.
- Duplicates and backpressure: idx1 and idx3 both data 0x77, keys 3 and 0; query 0x77 with r_ready=0 for 5 cycles → r_hit=1, r_key=3, r_idx=1 held stable; q_ready=0 until the cycle after the r_ready handshake.
- clr priority and mid-scan clear: clr and wr_en to idx3 in the same cycle → lut_vld=0. Reprogram idx3 = {key 2, data 0x11}, query 0x11, pulse clr on the 2nd scan cycle → r_hit=0.
- Out-of-range and async reset: NR_KEY=3, wr_idx=3 → no lut change. Assert rst_n low during SCAN → r_valid stays 0, q_ready=1, table cleared.
